// File: rtl/pc_unit.sv
// Program counter with priority redirect (branch > jump > return > stall > increment).
// Define PC_UNIT_RAS_EN to build in the circular return-address stack; otherwise call/ret are ignored.
module pc_unit #(
  parameter int WIDTH     = 7,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_top;
  logic             w_pop;

  assign w_pc_inc = r_pc + WIDTH'(STEP);
  assign pc       = r_pc;
  assign pc_inc   = w_pc_inc;

`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_empty;
  logic             r_full;
  logic             r_underflow;
  logic             w_ret_q;
  logic             w_push;
  logic             w_underflow;

  // A return only counts when no branch or jump outranks it.
  assign w_ret_q     = ret_en & ~branch_en & ~jump_en;
  assign w_push      = jump_en & call_en & ~branch_en;
  assign w_pop       = w_ret_q & (r_count != '0);
  assign w_underflow = w_ret_q & (r_count == '0);
  assign w_top       = r_stack[r_wp - 1'b1];

  always_comb begin
    w_count_next = r_count;
    if (w_push) begin
      if (r_count != DEPTH_C) w_count_next = r_count + 1'b1;
    end else if (w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Write pointer wraps, so a push when full lands on the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp        <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push)     r_wp <= r_wp + 1'b1;
      else if (w_pop) r_wp <= r_wp - 1'b1;
      r_count     <= w_count_next;
      r_empty     <= (w_count_next == '0);
      r_full      <= (w_count_next == DEPTH_C);
      r_underflow <= w_underflow;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_stack[r_wp] <= w_pc_inc;
  end

  assign ras_empty     = r_empty;
  assign ras_full      = r_full;
  assign ras_underflow = r_underflow;
`else
  logic w_unused;

  assign w_unused      = ^{call_en, ret_en};
  assign w_pop         = 1'b0;
  assign w_top         = r_pc;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    w_pc_next = w_pc_inc;
    if (branch_en)    w_pc_next = branch_target;
    else if (jump_en) w_pc_next = jump_target;
    else if (w_pop)   w_pc_next = w_top;
    else if (stall)   w_pc_next = r_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) r_pc <= WIDTH'(RESET_VEC);
    else       r_pc <= w_pc_next;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit (WIDTH=7, STEP=1, RESET_VEC=0, RAS_DEPTH=4).
// Covers both builds, with and without PC_UNIT_RAS_EN.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       reset, stall, branch_en, jump_en, call_en, ret_en;
  logic [6:0] branch_target, jump_target;
  logic [6:0] pc, pc_inc;
  logic       ras_empty, ras_full, ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       st;
    logic       br;
    logic [6:0] bt;
    logic       jp;
    logic [6:0] jt;
    logic       ca;
    logic       rt;
    logic [6:0] pc;
    logic       e;
    logic       f;
    logic       u;
  } vec_t;

  vec_t vecs[$];

  pc_unit #(.WIDTH(7), .STEP(1), .RESET_VEC(0), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_en(branch_en), .branch_target(branch_target),
    .jump_en(jump_en), .jump_target(jump_target),
    .call_en(call_en), .ret_en(ret_en),
    .pc(pc), .pc_inc(pc_inc),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic br, logic [6:0] bt, logic jp, logic [6:0] jt,
                              logic ca, logic rt, logic [6:0] epc, logic e, logic f, logic u);
    vec_t v;
    v.st = st; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.ca = ca; v.rt = rt; v.pc = epc; v.e = e; v.f = f; v.u = u;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [6:0] epc, logic e, logic f, logic u);
    logic [6:0] einc;
    einc = epc + 7'd1;
    chk({tag, " pc"}, int'(pc), int'(epc));
    chk({tag, " pc_inc"}, int'(pc_inc), int'(einc));
    chk({tag, " ras_empty"}, int'(ras_empty), int'(e));
    chk({tag, " ras_full"}, int'(ras_full), int'(f));
    chk({tag, " ras_underflow"}, int'(ras_underflow), int'(u));
  endtask

  task automatic drive(logic rs, vec_t v);
    @(negedge clk);
    reset = rs; stall = v.st; branch_en = v.br; branch_target = v.bt;
    jump_en = v.jp; jump_target = v.jt; call_en = v.ca; ret_en = v.rt;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(string tag, vec_t v);
    drive(1'b0, v);
    chk_all(tag, v.pc, v.e, v.f, v.u);
  endtask

  // Reset with every other control asserted, to prove reset overrides them.
  task automatic do_reset(string tag);
    drive(1'b1, mk(1, 1, 7'd99, 1, 7'd77, 1, 1, 0, 1, 0, 0));
    chk_all(tag, 7'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; branch_target = '0; jump_target = '0;

    do_reset("reset");

    // Free-running increment with wrap 127 -> 0.
    for (int i = 0; i <= 130; i++) begin
      chk($sformatf("run%0d pc", i), int'(pc), i % 128);
      chk($sformatf("run%0d pc_inc", i), int'(pc_inc), (i + 1) % 128);
      if (i < 130) drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    do_reset("reset2");

`ifdef PC_UNIT_RAS_EN
    //                st br bt  jp jt  ca rt   pc  e  f  u
    vecs.push_back(mk(0, 1, 10, 0, 0,  0, 0,  10, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0,  10, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0,  10, 1, 0, 0));
    vecs.push_back(mk(1, 1, 40, 0, 0,  0, 0,  40, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  41, 1, 0, 0));
    vecs.push_back(mk(0, 1, 5,  0, 0,  0, 0,   5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 60, 1, 0,  60, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  61, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,   6, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1,  0, 0,  0, 0,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 10, 1, 0,  10, 0, 0, 0));
    vecs.push_back(mk(0, 1, 11, 0, 0,  0, 0,  11, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 20, 1, 0,  20, 0, 0, 0));
    vecs.push_back(mk(0, 1, 21, 0, 0,  0, 0,  21, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 30, 1, 0,  30, 0, 0, 0));
    vecs.push_back(mk(0, 1, 31, 0, 0,  0, 0,  31, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 40, 1, 0,  40, 0, 1, 0));
    vecs.push_back(mk(0, 1, 41, 0, 0,  0, 0,  41, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  1, 50, 1, 0,  50, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  42, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  32, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  22, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  12, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  13, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  14, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 60, 1, 0,  60, 0, 0, 0));
    vecs.push_back(mk(0, 1, 99, 1, 70, 1, 1,  99, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  15, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 80, 1, 1,  80, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  16, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 1,  16, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0,  1, 0,  17, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 100,1, 0, 100, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0, 100, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 1,  18, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 30, 1, 0,  30, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 50, 1, 0,  50, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0,  50, 0, 0, 0));
`else
    //                st br bt  jp jt  ca rt   pc  e  f  u
    vecs.push_back(mk(0, 1, 5,  0, 0,  0, 0,   5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 60, 1, 0,  60, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  61, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  62, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 1,  62, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  1, 0,  63, 1, 0, 0));
    vecs.push_back(mk(0, 1, 99, 1, 70, 1, 1,  99, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 30, 1, 1,  30, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0,  30, 1, 0, 0));
`endif

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Reset during a stall with entries on the stack discards them all.
    do_reset("midreset");
`ifdef PC_UNIT_RAS_EN
    apply("postreset_ret", mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1));
    apply("postreset_inc", mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
`else
    apply("postreset_ret", mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    apply("postreset_inc", mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, PC width in bits.
REQ-002 The block SHALL have parameter STEP, default 1, increment added per sequential fetch.
REQ-003 The block SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4, return-address stack entries (power of two, >=2).
REQ-005 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port stall  input  1  hold PC this cycle.
REQ-008 The block SHALL have port branch_en  input  1  take conditional branch redirect.
REQ-009 The block SHALL have port branch_target  input  WIDTH  branch destination.
REQ-010 The block SHALL have port jump_en  input  1  take unconditional jump.
REQ-011 The block SHALL have port jump_target  input  WIDTH  jump destination.
REQ-012 The block SHALL have port call_en  input  1  qualifies jump_en as call (push return address).
REQ-013 The block SHALL have port ret_en  input  1  return: pop stack into PC.
REQ-014 The block SHALL have port pc  output  WIDTH  registered current PC.
REQ-015 The block SHALL have port pc_inc  output  WIDTH  combinational pc+STEP.
REQ-016 The block SHALL have ports ras_empty, ras_full  output  1 each  stack status, registered.
REQ-017 The block SHALL have port ras_underflow  output  1  one-cycle pulse on pop of empty stack.

Function
REQ-018 pc_inc SHALL equal (pc+STEP) mod 2^WIDTH; carry out discarded, e.g. WIDTH=7: 127+1 -> 0.
REQ-019 Next-PC priority SHALL be: reset > branch_en > jump_en > ret_en > stall > increment.
REQ-020 Latency SHALL be one cycle: controls sampled at edge N appear on pc after edge N.
REQ-021 branch_en=1 SHALL load branch_target regardless of stall, jump_en, ret_en; no stack change.
REQ-022 jump_en=1 (branch_en=0) SHALL load jump_target; with call_en=1 it SHALL also push pc_inc.
REQ-023 call_en without jump_en SHALL be ignored.
REQ-024 ret_en=1 (no branch/jump) with non-empty stack SHALL load top entry into pc and pop.
REQ-025 ret_en=1 on empty stack SHALL increment pc normally (or hold if stall=1) and pulse ras_underflow for one cycle.
REQ-026 Push when full SHALL overwrite the oldest entry (circular); count SHALL stay RAS_DEPTH, ras_full stays 1.
REQ-027 Simultaneous call (jump_en&call_en) and ret_en SHALL perform the call only; ret ignored, no underflow pulse.
REQ-028 A push or pop suppressed by branch_en SHALL leave stack unchanged.
REQ-029 stall=1 with no redirect SHALL hold pc and stack unchanged.
REQ-030 ras_empty SHALL be 1 iff count=0; ras_full SHALL be 1 iff count=RAS_DEPTH.

Reset
REQ-031 reset=1 at an edge SHALL set pc=RESET_VEC, stack count=0, ras_empty=1, ras_full=0, ras_underflow=0, overriding all other inputs.
REQ-032 Reset asserted mid-sequence (e.g. during stall or after pushes) SHALL discard all stack contents; first post-reset fetch SHALL be RESET_VEC.

Configuration
REQ-033 Macro PC_UNIT_RAS_EN SHALL compile in the return-address stack and REQ-022 push, REQ-024..028 stack behaviour.
REQ-034 Without PC_UNIT_RAS_EN, all ports SHALL remain; call_en and ret_en SHALL be ignored (ret acts as no-op, pc increments), ras_empty tied 1, ras_full and ras_underflow tied 0, no stack storage synthesized.

Verification (WIDTH=7, STEP=1, RESET_VEC=0, RAS_DEPTH=4, macro defined unless stated)
REQ-035 Reset then 130 free-running cycles -> pc 0,1,...,127,0,1,2; pc_inc always pc+1 mod 128.
REQ-036 pc=10, stall=1 for 3 cycles, branch_en=1 target 40 on 3rd cycle -> pc 10,10,40, then 41.
REQ-037 pc=5 jump_en+call_en target 60; at 61 ret_en -> pc 60,61,6; ras_empty 0 after call, 1 after ret.
REQ-038 Five calls from pc 1,11,21,31,41 (targets 10,20,30,40,50) then five rets -> pops 42,32,22,12 then underflow pulse, pc increments; ras_full=1 after 4th call.
REQ-039 Same cycle jump_en+call_en+ret_en with branch_en=1 target 99 -> pc=99, stack count unchanged; then reset mid-stall -> pc=0, ras_empty=1.
REQ-040 Macro undefined: call then ret from pc=5 target 60 -> pc 60,61,62; ras_empty=1, ras_underflow=0 throughout.
